// File: rtl/sp_mem_pipe_if.sv
// Request/response bundle for sp_mem_pipe: valid/ready request plus read response and error pulse.
interface sp_mem_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic                  valid;
    logic                  ready;
    logic                  wr_rd;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     rdata;
    logic                  rvalid;
    logic                  err;

    modport master (
        output valid, wr_rd, addr, wdata, be,
        input  ready, rdata, rvalid, err
    );

    modport slave (
        input  valid, wr_rd, addr, wdata, be,
        output ready, rdata, rvalid, err
    );
endinterface

// File: rtl/sp_mem_pipe.sv
// Single-port scratch RAM with byte-enable writes, 1- or 2-cycle read pipeline
// and a zero-fill sweep that runs after reset and on every clr request.
module sp_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 2**ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    sp_mem_pipe_if.slave     bus,
    output logic             init_done
);
    localparam int NB     = DATA_W / 8;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DEPTH_U = DEPTH;
    localparam int unsigned LAST_U  = DEPTH - 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = DEPTH_U[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_PTR = LAST_U[ADDR_W-1:0];

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t              state_r, state_nxt_s;
    logic [ADDR_W-1:0]   ptr_r, ptr_nxt_s;
    logic                ready_s, flush_s, accept_s, rd_acc_s, wr_acc_s, oob_s;
    logic                init_done_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic                s1_v_r, s1_e_r, s2_v_r, s2_e_r, rvalid_r, err_r;
    logic [DATA_W-1:0]   s1_d_r, s2_d_r, rdata_r;

    // Replace only the enabled byte lanes of a stored word.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be_v
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be_v[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Next-state, sweep pointer and request acceptance.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        ready_s     = 1'b0;
        flush_s     = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (clr) begin
                    ptr_nxt_s = '0;
                end else if (ptr_r == LAST_PTR) begin
                    state_nxt_s = ST_RUN;
                    ptr_nxt_s   = '0;
                end else begin
                    ptr_nxt_s = ptr_r + ADDR_W'(1'b1);
                end
            end
            ST_RUN: begin
                if (clr) begin
                    state_nxt_s = ST_INIT;
                    ptr_nxt_s   = '0;
                    flush_s     = 1'b1;
                end else begin
                    ready_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
                ptr_nxt_s   = '0;
            end
        endcase
        accept_s = bus.valid && ready_s;
        rd_acc_s = accept_s && !bus.wr_rd;
        wr_acc_s = accept_s && bus.wr_rd;
        oob_s    = ({1'b0, bus.addr} >= DEPTH_L);
    end

    // Control state, sweep pointer and init_done flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_INIT;
            ptr_r       <= '0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            init_done_r <= (state_nxt_s == ST_RUN);
        end
    end

    // Storage array: zero-fill sweep or byte-masked write; untouched while rst is held.
    always_ff @(posedge clk) begin
        if (rst && (state_r == ST_INIT)) begin
            mem_r[ptr_r[MEM_AW-1:0]] <= '0;
        end else if (rst && wr_acc_s && !oob_s) begin
            mem_r[bus.addr[MEM_AW-1:0]] <= byte_merge(mem_r[bus.addr[MEM_AW-1:0]], bus.wdata, bus.be);
        end
    end

    // Read pipeline; data registers only load with a valid entry so rdata holds between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v_r   <= 1'b0;
            s1_e_r   <= 1'b0;
            s1_d_r   <= '0;
            s2_v_r   <= 1'b0;
            s2_e_r   <= 1'b0;
            s2_d_r   <= '0;
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= '0;
        end else if (flush_s) begin
            s1_v_r   <= 1'b0;
            s1_e_r   <= 1'b0;
            s2_v_r   <= 1'b0;
            s2_e_r   <= 1'b0;
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            s1_v_r <= rd_acc_s;
            s1_e_r <= rd_acc_s && oob_s;
            if (rd_acc_s) begin
                s1_d_r <= oob_s ? '0 : mem_r[bus.addr[MEM_AW-1:0]];
            end
            s2_v_r <= s1_v_r;
            s2_e_r <= s1_e_r;
            if (s1_v_r) begin
                s2_d_r <= s1_d_r;
            end
            // Write errors report right after acceptance; read errors ride with their rvalid.
            if (RD_LAT == 2) begin
                rvalid_r <= s2_v_r;
                err_r    <= s2_e_r || (wr_acc_s && oob_s);
                if (s2_v_r) begin
                    rdata_r <= s2_d_r;
                end
            end else begin
                rvalid_r <= s1_v_r;
                err_r    <= s1_e_r || (wr_acc_s && oob_s);
                if (s1_v_r) begin
                    rdata_r <= s1_d_r;
                end
            end
        end
    end

    assign bus.ready  = ready_s;
    assign bus.rdata  = rdata_r;
    assign bus.rvalid = rvalid_r;
    assign bus.err    = err_r;
    assign init_done  = init_done_r;
endmodule

// File: tb/tb_sp_mem_pipe.sv
// Directed bench: u0 (DEPTH=12, RD_LAT=2) and u1 (DEPTH=16, RD_LAT=1) share clock and reset.
module tb_sp_mem_pipe;
    logic clk;
    logic rst;
    logic clr0, clr1;
    logic done0, done1;
    int   n_assert;
    int   n_fail;

    sp_mem_pipe_if #(.DATA_W(32), .ADDR_W(4)) if0 ();
    sp_mem_pipe_if #(.DATA_W(32), .ADDR_W(4)) if1 ();

    sp_mem_pipe #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_LAT(2)) u0 (
        .clk(clk), .rst(rst), .clr(clr0), .bus(if0.slave), .init_done(done0)
    );
    sp_mem_pipe #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr1), .bus(if1.slave), .init_done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv0(input logic v, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] b);
        if0.valid = v; if0.wr_rd = w; if0.addr = a; if0.wdata = d; if0.be = b;
    endtask

    task automatic drv1(input logic v, input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] b);
        if1.valid = v; if1.wr_rd = w; if1.addr = a; if1.wdata = d; if1.be = b;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst  = 1'b0;
        clr0 = 1'b0;
        clr1 = 1'b0;
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        drv1(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);

        // reset values
        check("rst_ready",  32'(if0.ready),  32'h0);
        check("rst_rvalid", 32'(if0.rvalid), 32'h0);
        check("rst_err",    32'(if0.err),    32'h0);
        check("rst_done",   32'(done0),      32'h0);
        check("rst_rdata",  if0.rdata,       32'h0);

        // init sweep: u0 ready after 12 edges, u1 after 16
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            check("init_ready0", 32'(if0.ready), (k >= 12) ? 32'h1 : 32'h0);
            check("init_done0",  32'(done0),     (k >= 12) ? 32'h1 : 32'h0);
            check("init_ready1", 32'(if1.ready), (k >= 16) ? 32'h1 : 32'h0);
            check("init_done1",  32'(done1),     (k >= 16) ? 32'h1 : 32'h0);
        end

        // read back all 12 words, back-to-back, RD_LAT=2
        for (int i = 0; i < 15; i++) begin
            if (i < 12) drv0(1'b1, 1'b0, 4'(i), 32'h0, 4'h0);
            else        drv0(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
            cyc();
            check("sweep_rvalid", 32'(if0.rvalid), (i >= 2 && i < 14) ? 32'h1 : 32'h0);
            if (i >= 2 && i < 14) check("sweep_rdata", if0.rdata, 32'h0);
        end

        // byte enables, including a be=0 write
        drv0(1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'hF);  cyc();
        drv0(1'b1, 1'b1, 4'd3, 32'h11223344, 4'h5);  cyc();
        drv0(1'b1, 1'b1, 4'd3, 32'h00000000, 4'h0);  cyc();
        check("be0_err", 32'(if0.err), 32'h0);
        drv0(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);         cyc();
        check("be_lat0", 32'(if0.rvalid), 32'h0);
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);         cyc();
        check("be_lat1", 32'(if0.rvalid), 32'h0);
        cyc();
        check("be_rvalid", 32'(if0.rvalid), 32'h1);
        check("be_rdata",  if0.rdata, 32'hAA22CC44);
        cyc();
        check("be_rvalid_end", 32'(if0.rvalid), 32'h0);
        check("be_rdata_hold", if0.rdata, 32'hAA22CC44);

        // back-to-back write then two reads
        drv0(1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 4'hF);  cyc();
        check("b2b_werr", 32'(if0.err), 32'h0);
        drv0(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);         cyc();
        drv0(1'b1, 1'b0, 4'd6, 32'h0, 4'h0);         cyc();
        check("b2b_lat", 32'(if0.rvalid), 32'h0);
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);         cyc();
        check("b2b_rv0", 32'(if0.rvalid), 32'h1);
        check("b2b_rd0", if0.rdata, 32'hDEADBEEF);
        cyc();
        check("b2b_rv1", 32'(if0.rvalid), 32'h1);
        check("b2b_rd1", if0.rdata, 32'h0);
        cyc();
        check("b2b_rv_end", 32'(if0.rvalid), 32'h0);

        // out-of-range write and read
        drv0(1'b1, 1'b1, 4'd13, 32'hFFFFFFFF, 4'hF); cyc();
        check("oob_werr", 32'(if0.err), 32'h1);
        drv0(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);         cyc();
        check("oob_werr_end", 32'(if0.err), 32'h0);
        drv0(1'b1, 1'b0, 4'd14, 32'h0, 4'h0);        cyc();
        check("oob_gap_err", 32'(if0.err),    32'h0);
        check("oob_gap_rv",  32'(if0.rvalid), 32'h0);
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);         cyc();
        check("oob_rv5",  32'(if0.rvalid), 32'h1);
        check("oob_rd5",  if0.rdata,       32'hDEADBEEF);
        check("oob_err5", 32'(if0.err),    32'h0);
        cyc();
        check("oob_rv14",  32'(if0.rvalid), 32'h1);
        check("oob_rd14",  if0.rdata,       32'h0);
        check("oob_err14", 32'(if0.err),    32'h1);
        cyc();
        check("oob_rv_end",  32'(if0.rvalid), 32'h0);
        check("oob_err_end", 32'(if0.err),    32'h0);

        // clr flushes an in-flight read and reruns the sweep
        drv0(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);         cyc();
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        clr0 = 1'b1;
        #1;
        check("clr_ready", 32'(if0.ready), 32'h0);
        cyc();
        clr0 = 1'b0;
        check("clr_rvalid", 32'(if0.rvalid), 32'h0);
        check("clr_done",   32'(done0),      32'h0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check("clr_sweep_rvalid", 32'(if0.rvalid), 32'h0);
            check("clr_sweep_ready",  32'(if0.ready), (k == 12) ? 32'h1 : 32'h0);
            check("clr_sweep_done",   32'(done0),     (k == 12) ? 32'h1 : 32'h0);
        end
        drv0(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);         cyc();
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);         cyc();
        cyc();
        check("clr_rd_rv", 32'(if0.rvalid), 32'h1);
        check("clr_rd",    if0.rdata,       32'h0);

        // RD_LAT=1 back-to-back on u1; addr 15 is in range
        drv1(1'b1, 1'b1, 4'd5,  32'hDEADBEEF, 4'hF); cyc();
        drv1(1'b1, 1'b1, 4'd15, 32'h5A5A5A5A, 4'hF); cyc();
        check("l1_err15", 32'(if1.err), 32'h0);
        drv1(1'b1, 1'b0, 4'd5,  32'h0, 4'h0);        cyc();
        check("l1_lat", 32'(if1.rvalid), 32'h0);
        drv1(1'b1, 1'b0, 4'd6,  32'h0, 4'h0);        cyc();
        check("l1_rv5", 32'(if1.rvalid), 32'h1);
        check("l1_rd5", if1.rdata,       32'hDEADBEEF);
        drv1(1'b1, 1'b0, 4'd15, 32'h0, 4'h0);        cyc();
        check("l1_rv6", 32'(if1.rvalid), 32'h1);
        check("l1_rd6", if1.rdata,       32'h0);
        drv1(1'b0, 1'b0, 4'h0,  32'h0, 4'h0);        cyc();
        check("l1_rv15",  32'(if1.rvalid), 32'h1);
        check("l1_rd15",  if1.rdata,       32'h5A5A5A5A);
        check("l1_err_r", 32'(if1.err),    32'h0);
        cyc();
        check("l1_rv_end", 32'(if1.rvalid), 32'h0);

        // reset mid-operation discards a pending read
        drv0(1'b1, 1'b0, 4'd3, 32'h0, 4'h0);         cyc();
        drv0(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(if0.ready), 32'h0);
        check("mid_rst_done",  32'(done0),     32'h0);
        check("mid_rst_rdata", if0.rdata,      32'h0);
        cyc();
        cyc();
        check("mid_rst_rvalid", 32'(if0.rvalid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
